audio_pcm_reader: RTL and testbench

Downstream consumer of the audio sample FIFO. Paces reads from the FIFO with a phase accumulator driven by the audio sample tick, and assembles 8/16-bit mono/stereo frames from the byte stream. Applies a 4-bit volume and presents signed 16-bit left/right samples to the audio mixer/DAC stage.

---
 rtl/audio_pcm_reader.sv | 195 +++++++++++++++++++
 tb/tb_audio_pcm_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pcm_reader.sv
// Audio sample FIFO consumer: phase-accumulator paced frame fetch, 8/16-bit mono/stereo
// assembly and 4-bit volume. Define AUDIO_PCM_UNDERRUN_CNT_EN to add the underrun_count port.
module audio_pcm_reader #(
    parameter int ACC_BITS = 7,
    parameter int RATE_MAX = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    input  logic [7:0]  rate,
    input  logic        mode_stereo,
    input  logic        mode_16bit,
    input  logic [3:0]  volume,
    input  logic [7:0]  fifo_rddata,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [15:0] left_out,
    output logic [15:0] right_out,
    output logic        out_valid,
`ifdef AUDIO_PCM_UNDERRUN_CNT_EN
    output logic [7:0]  underrun_count,
`endif
    output logic        underrun
);

    typedef enum logic [1:0] {IDLE, FETCH, ASSEMBLE, SCALE} state_t;

    state_t                state_q, state_d;
    logic [ACC_BITS-1:0]   acc_q, acc_d;
    logic [ACC_BITS:0]     acc_sum, rate_c;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            last_idx;
    logic                  rd_pend_q, rd_pend_d;
    logic [1:0]            rd_idx_q, rd_idx_d;
    logic [3:0][7:0]       bytes_q, bytes_d;
    logic                  miss_q, miss_d;
    logic                  stereo_q, stereo_d;
    logic                  b16_q, b16_d;
    logic [3:0]            vol_q, vol_d;
    logic [15:0]           samp_l_q, samp_l_d;
    logic [15:0]           samp_r_q, samp_r_d;
    logic [15:0]           left_q, left_d;
    logic [15:0]           right_q, right_d;
    logic                  out_valid_q, out_valid_d;
    logic                  underrun_q, underrun_d;
    logic                  rd_en;

    // Product is 21-bit signed; the >>> rounds toward minus infinity before truncation.
    function automatic logic [15:0] scale(input logic [15:0] s, input logic [3:0] v);
        logic signed [20:0] p;
        logic signed [20:0] sh;
        if (v == 4'd0) return 16'h0000;
        p  = $signed({{5{s[15]}}, s}) * $signed(21'({1'b0, v}) + 21'd1);
        sh = p >>> 4;
        return sh[15:0];
    endfunction

    // Index of the final byte slot: 0, 1, 1, 3 for frame sizes 1, 2, 2, 4.
    assign last_idx = {stereo_q & b16_q, stereo_q | b16_q};

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        rd_pend_d   = 1'b0;
        rd_idx_d    = rd_idx_q;
        bytes_d     = bytes_q;
        miss_d      = miss_q;
        stereo_d    = stereo_q;
        b16_d       = b16_q;
        vol_d       = vol_q;
        samp_l_d    = samp_l_q;
        samp_r_d    = samp_r_q;
        left_d      = left_q;
        right_d     = right_q;
        out_valid_d = 1'b0;
        underrun_d  = 1'b0;
        rd_en       = 1'b0;

        rate_c  = (32'(rate) > RATE_MAX) ? (ACC_BITS+1)'(RATE_MAX) : (ACC_BITS+1)'(rate);
        acc_sum = {1'b0, acc_q} + rate_c;
        if (sample_tick) acc_d = acc_sum[ACC_BITS-1:0];

        // Read data arrives one cycle after its request, including the last byte during ASSEMBLE.
        if (rd_pend_q) bytes_d[rd_idx_q] = fifo_rddata;

        case (state_q)
            IDLE: begin
                if (sample_tick && acc_sum[ACC_BITS]) begin
                    state_d  = FETCH;
                    cnt_d    = 2'd0;
                    miss_d   = 1'b0;
                    bytes_d  = '0;
                    stereo_d = mode_stereo;
                    b16_d    = mode_16bit;
                    vol_d    = volume;
                end
            end
            FETCH: begin
                rd_en = !fifo_empty;
                if (rd_en) begin
                    rd_pend_d = 1'b1;
                    rd_idx_d  = cnt_q;
                end else begin
                    miss_d = 1'b1;
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_idx) state_d = ASSEMBLE;
            end
            ASSEMBLE: begin
                if (b16_q) begin
                    samp_l_d = {bytes_d[1], bytes_d[0]};
                    samp_r_d = stereo_q ? {bytes_d[3], bytes_d[2]} : {bytes_d[1], bytes_d[0]};
                end else begin
                    samp_l_d = {bytes_d[0], 8'h00};
                    samp_r_d = stereo_q ? {bytes_d[1], 8'h00} : {bytes_d[0], 8'h00};
                end
                state_d = SCALE;
            end
            SCALE: begin
                left_d      = scale(samp_l_q, vol_q);
                right_d     = scale(samp_r_q, vol_q);
                out_valid_d = 1'b1;
                underrun_d  = miss_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            rd_pend_q   <= 1'b0;
            rd_idx_q    <= '0;
            // NOTE: the byte store is tiny, so it is reset along with everything else.
            bytes_q     <= '0;
            miss_q      <= 1'b0;
            stereo_q    <= 1'b0;
            b16_q       <= 1'b0;
            vol_q       <= '0;
            samp_l_q    <= '0;
            samp_r_q    <= '0;
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_idx_q    <= rd_idx_d;
            bytes_q     <= bytes_d;
            miss_q      <= miss_d;
            stereo_q    <= stereo_d;
            b16_q       <= b16_d;
            vol_q       <= vol_d;
            samp_l_q    <= samp_l_d;
            samp_r_q    <= samp_r_d;
            left_q      <= left_d;
            right_q     <= right_d;
            out_valid_q <= out_valid_d;
            underrun_q  <= underrun_d;
        end
    end

`ifdef AUDIO_PCM_UNDERRUN_CNT_EN
    logic [7:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (state_q == SCALE && miss_q && ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) ucnt_q <= '0;
        else     ucnt_q <= ucnt_d;
    end

    assign underrun_count = ucnt_q;
`endif

    // Reads are suppressed while reset is held even though the state register has not yet cleared.
    assign fifo_rd_en = rd_en && !rst;
    assign left_out   = left_q;
    assign right_out  = right_q;
    assign out_valid  = out_valid_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_audio_pcm_reader.sv
// Scoreboard bench for audio_pcm_reader: directed frames push expectations, a negedge monitor checks them.
module tb_audio_pcm_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic [7:0]  rate = 8'd0;
    logic        mode_stereo = 1'b0;
    logic        mode_16bit = 1'b0;
    logic [3:0]  volume = 4'd0;
    logic [7:0]  fifo_rddata = 8'h00;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] left_out;
    logic [15:0] right_out;
    logic        out_valid;
    logic        underrun;
`ifdef AUDIO_PCM_UNDERRUN_CNT_EN
    logic [7:0]  underrun_count;
`endif

    always #5 clk = ~clk;

    audio_pcm_reader dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .rate        (rate),
        .mode_stereo (mode_stereo),
        .mode_16bit  (mode_16bit),
        .volume      (volume),
        .fifo_rddata (fifo_rddata),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .left_out    (left_out),
        .right_out   (right_out),
        .out_valid   (out_valid),
`ifdef AUDIO_PCM_UNDERRUN_CNT_EN
        .underrun_count (underrun_count),
`endif
        .underrun    (underrun)
    );

    typedef struct {
        int          cyc;
        logic [15:0] l;
        logic [15:0] r;
        logic        u;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte FIFO model: data appears the cycle after an accepted read.
    logic [7:0] mem [16];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       fifo_flush = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rddata <= mem[rd_ptr % 16];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("out_cycle", cyc, mon_e.cyc);
                check("left_out", left_out, mon_e.l);
                check("right_out", right_out, mon_e.r);
                check("underrun", underrun, mon_e.u);
            end
        end
    end

    task automatic load_fifo(input int nb, input logic [31:0] bytes);
        for (int i = 0; i < nb; i++) begin
            mem[wr_ptr % 16] = bytes[8*i +: 8];
            wr_ptr++;
        end
    endtask

    task automatic flush_fifo();
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
    endtask

    // Issues one tick in the current cycle and checks the read window T+1..T+exp_reads.
    task automatic run_frame(input logic st, input logic b16, input logic [3:0] vol,
                             input logic [7:0] rt, input int nb, input logic [31:0] bytes,
                             input int exp_reads, input logic [15:0] el, input logic [15:0] er,
                             input logic eu, input logic extra);
        int n, t, nrd, first, last;
        load_fifo(nb, bytes);
        n = (st ? 2 : 1) * (b16 ? 2 : 1);
        mode_stereo = st;
        mode_16bit  = b16;
        volume      = vol;
        rate        = rt;
        sample_tick = 1'b1;
        t = cyc;
        sb.push_back('{t + n + 3, el, er, eu});
        @(negedge clk);
        sample_tick = extra;
        mode_stereo = ~st;
        mode_16bit  = ~b16;
        volume      = ~vol;
        nrd = 0;
        first = -1;
        last = -1;
        for (int i = 1; i <= n + 6; i++) begin
            if (fifo_rd_en) begin
                nrd++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            @(negedge clk);
            sample_tick = 1'b0;
        end
        check("read_count", nrd, exp_reads);
        if (exp_reads > 0) begin
            check("first_read_cycle", first, t + 1);
            check("last_read_cycle", last, t + exp_reads);
        end
    endtask

    initial begin
        int nrd;
        repeat (3) @(negedge clk);
        check("rst_left", left_out, 16'h0000);
        check("rst_right", right_out, 16'h0000);
        check("rst_valid", out_valid, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(1'b0, 1'b0, 4'd15, 8'd128, 1, 32'h40, 1, 16'h4000, 16'h4000, 1'b0, 1'b0);
        run_frame(1'b1, 1'b1, 4'd15, 8'd128, 4, 32'hABCD1234, 4, 16'h1234, 16'hABCD, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 4'd7, 8'd128, 1, 32'h80, 1, 16'hC000, 16'hC000, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 4'd0, 8'd128, 1, 32'h80, 1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        run_frame(1'b1, 1'b0, 4'd15, 8'd128, 2, 32'h817F, 2, 16'h7F00, 16'h8100, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 4'd3, 8'd128, 2, 32'hABCD, 2, 16'hEAF3, 16'hEAF3, 1'b0, 1'b0);
        // Second tick while busy must be dropped.
        run_frame(1'b0, 1'b0, 4'd15, 8'd128, 1, 32'h40, 1, 16'h4000, 16'h4000, 1'b0, 1'b1);
        // Rate above RATE_MAX is clamped to one frame per tick.
        run_frame(1'b0, 1'b0, 4'd15, 8'd200, 1, 32'h05, 1, 16'h0500, 16'h0500, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 4'd15, 8'd200, 1, 32'hFB, 1, 16'hFB00, 16'hFB00, 1'b0, 1'b0);

        run_frame(1'b1, 1'b1, 4'd15, 8'd128, 2, 32'h1000, 2, 16'h1000, 16'h0000, 1'b1, 1'b0);
`ifdef AUDIO_PCM_UNDERRUN_CNT_EN
        check("underrun_count_inc", underrun_count, 8'd1);
`endif
        run_frame(1'b0, 1'b0, 4'd15, 8'd128, 1, 32'h01, 1, 16'h0100, 16'h0100, 1'b0, 1'b0);

        // rate=32: frames on ticks 4, 8, 12, 16.
        load_fifo(4, 32'h44332211);
        mode_stereo = 1'b0;
        mode_16bit  = 1'b0;
        volume      = 4'd15;
        rate        = 8'd32;
        nrd = 0;
        for (int i = 1; i <= 16; i++) begin
            sample_tick = 1'b1;
            if (i == 4)  sb.push_back('{cyc + 4, 16'h1100, 16'h1100, 1'b0});
            if (i == 8)  sb.push_back('{cyc + 4, 16'h2200, 16'h2200, 1'b0});
            if (i == 12) sb.push_back('{cyc + 4, 16'h3300, 16'h3300, 1'b0});
            if (i == 16) sb.push_back('{cyc + 4, 16'h4400, 16'h4400, 1'b0});
            @(negedge clk);
            sample_tick = 1'b0;
            for (int j = 0; j < 8; j++) begin
                if (fifo_rd_en) nrd++;
                @(negedge clk);
            end
        end
        check("rate32_reads", nrd, 4);

        // rate=0 never fetches, even with data waiting.
        load_fifo(1, 32'h55);
        rate = 8'd0;
        nrd = 0;
        for (int i = 0; i < 4; i++) begin
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
            for (int j = 0; j < 6; j++) begin
                if (fifo_rd_en) nrd++;
                @(negedge clk);
            end
        end
        check("rate0_reads", nrd, 0);
        flush_fifo();

        // Reset in the middle of a 4-byte fetch aborts the frame.
        load_fifo(4, 32'hDDCCBBAA);
        mode_stereo = 1'b1;
        mode_16bit  = 1'b1;
        volume      = 4'd15;
        rate        = 8'd128;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rd_en_in_reset", fifo_rd_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check("abort_left", left_out, 16'h0000);
        check("abort_right", right_out, 16'h0000);
`ifdef AUDIO_PCM_UNDERRUN_CNT_EN
        check("underrun_count_rst", underrun_count, 8'd0);
`endif
        repeat (8) @(negedge clk);
        flush_fifo();
        run_frame(1'b1, 1'b1, 4'd15, 8'd128, 4, 32'h04030201, 4, 16'h0201, 16'h0403, 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_out_valid: got none expected output at cycle %0d", mon_e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
